// File: rtl/uart_pkg.sv
// Shared types and legal-value limits for the uart_tx_gen2 transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

  // Even parity over the (zero-extended) character, flipped for odd sense.
  function automatic logic parity_of(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Character FIFO for the UART transmitter; first-word fall-through read port.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == {(AW+1){1'b0}});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1'b1);
      2'b01:   count_d = count_q - (AW+1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1'b1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_gen2.sv
// FIFO-fed UART transmitter, LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx_gen2
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int STOP_CYCLES  = STOP_BITS * CLKS_PER_BIT;
  localparam int CW           = $clog2(STOP_CYCLES);
  localparam int BW           = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : g_chk_baud
    $error("CLOCK_FREQ / BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_chk_data
    $error("DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_chk_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_parity
    $error("PARITY_ODD must be 0 or 1");
  end

  tx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 bit_done;
  logic                 stop_done;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_done  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign stop_done = (cnt_q == CW'(STOP_CYCLES - 1));
  assign s_ready   = !fifo_full;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  // A character leaves the FIFO when idle, or on the last stop cycle for back-to-back frames.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      case (state_q)
        IDLE:    fifo_pop = 1'b1;
        STOP:    fifo_pop = stop_done;
        default: fifo_pop = 1'b0;
      endcase
    end else begin
      fifo_pop = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          tx_q  <= 1'b1;
          if (fifo_pop) begin
            state_q  <= START;
            shift_q  <= fifo_rdata;
            tx_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_of(DATA_BITS_MAX'(fifo_rdata), PARITY_ODD != 0);
`endif
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1'b1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + BW'(1'b1);
              shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1'b1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1'b1);
          end
        end
`endif
        STOP: begin
          if (stop_done) begin
            cnt_q <= '0;
            if (fifo_pop) begin
              state_q  <= START;
              shift_q  <= fifo_rdata;
              tx_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
              parity_q <= parity_of(DATA_BITS_MAX'(fifo_rdata), PARITY_ODD != 0);
`endif
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1'b1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Bench for uart_tx_gen2: an 8N1 and a 7-data/2-stop instance checked each cycle
// against a line-level model (expected tx waveform queue), plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_tx_gen2;
  localparam int CPB   = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB      = 1;
  localparam int LEN_8N1 = 110;
  localparam int LEN_7N2 = 110;
`else
  localparam int PB      = 0;
  localparam int LEN_8N1 = 100;
  localparam int LEN_7N2 = 100;
`endif

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] s_valid = 2'b00;
  logic [7:0] d0      = 8'h00;
  logic [6:0] d1      = 7'h00;
  logic [1:0] rdy;
  logic [1:0] txl;
  logic [1:0] bsy;
  logic [2:0] cnt0;
  logic [2:0] cnt1;
  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_gen2 #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid[0]), .s_data(d0), .s_ready(rdy[0]),
    .tx(txl[0]), .busy(bsy[0]), .fifo_count(cnt0));

  uart_tx_gen2 #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .STOP_BITS(2),
                 .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid[1]), .s_data(d1), .s_ready(rdy[1]),
    .tx(txl[1]), .busy(bsy[1]), .fifo_count(cnt1));

  function automatic int db_of(input int i);  return (i == 0) ? 8 : 7; endfunction
  function automatic int sb_of(input int i);  return (i == 0) ? 1 : 2; endfunction
  function automatic int odd_of(input int i); return (i == 0) ? 0 : 1; endfunction
  function automatic int cnt_of(input int i); return (i == 0) ? int'(cnt0) : int'(cnt1); endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Line model: every accepted character appends its whole waveform, one entry per clock.
  logic [1:0] line_q [2][$];
  logic [1:0] m_tx   = 2'b11;
  logic [1:0] m_infr = 2'b00;
  int         m_cnt [2];
  logic [1:0] m_e;
  bit         m_take;

  task automatic push_frame(input int i, input int data);
    int par = odd_of(i);
    for (int c = 0; c < CPB; c++) line_q[i].push_back((c == 0) ? 2'b10 : 2'b00);
    for (int b = 0; b < db_of(i); b++) begin
      par = par ^ ((data >> b) & 1);
      for (int c = 0; c < CPB; c++) line_q[i].push_back({1'b0, 1'((data >> b) & 1)});
    end
    if (PB != 0)
      for (int c = 0; c < CPB; c++) line_q[i].push_back({1'b0, 1'(par)});
    for (int c = 0; c < sb_of(i) * CPB; c++) line_q[i].push_back(2'b01);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        line_q[i].delete();
        m_cnt[i] = 0;
      end
      m_tx   = 2'b11;
      m_infr = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_take = (m_cnt[i] < DEPTH);
        if (line_q[i].size() > 0) begin
          m_e       = line_q[i].pop_front();
          m_tx[i]   = m_e[0];
          m_infr[i] = 1'b1;
          if (m_e[1]) m_cnt[i]--;
        end else begin
          m_tx[i]   = 1'b1;
          m_infr[i] = 1'b0;
        end
        if (s_valid[i] && m_take) begin
          push_frame(i, (i == 0) ? int'(d0) : int'(d1));
          m_cnt[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tx%0d", i), int'(txl[i]), int'(m_tx[i]));
      check($sformatf("busy%0d", i), int'(bsy[i]), int'(m_infr[i] || m_cnt[i] > 0));
      check($sformatf("ready%0d", i), int'(rdy[i]), int'(m_cnt[i] < DEPTH));
      check($sformatf("count%0d", i), cnt_of(i), m_cnt[i]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send1(input int i, input int data, output int acc);
    @(negedge clk);
    s_valid[i] = 1'b1;
    if (i == 0) d0 = data[7:0]; else d1 = data[6:0];
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    s_valid[i] = 1'b0;
  endtask

  task automatic capture(input int i, output int data, output int par, output int st);
    int n = 0;
    data = 0;
    par  = 0;
    st   = cyc;
    do begin
      tick(1);
      n++;
    end while (txl[i] != 1'b0 && n < 400);
    if (txl[i] != 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL start_timeout%0d: line still idle after %0d cycles, expected a start bit", i, n);
      return;
    end
    st = cyc;
    tick(5);
    for (int b = 0; b < db_of(i); b++) begin
      tick(CPB);
      data = data | (int'(txl[i]) << b);
    end
    if (PB != 0) begin
      tick(CPB);
      par = int'(txl[i]);
    end
    for (int s = 0; s < sb_of(i); s++) begin
      tick(CPB);
      check($sformatf("stop%0d", i), int'(txl[i]), 1);
    end
  endtask

  task automatic wait_idle(input int i, output int en);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (bsy[i] && n < 1000);
    if (bsy[i]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout%0d: busy still 1 after %0d cycles, expected 0", i, n);
    end
    en = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, st, en, dat, par, prev, dat2, par2, st2;
    bit saw_full;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    prev     = 0;
    saw_full = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx", int'(txl[0]), 1);
    check("rst_busy", int'(bsy[0]), 0);
    check("rst_ready", int'(rdy[0]), 1);
    check("rst_count", int'(cnt0), 0);
    reset = 1'b0;

    // 8N1 single character 0xA5
    send1(0, 8'hA5, acc);
    capture(0, dat, par, st);
    check("a5_latency", st - acc, 1);
    check("a5_data", dat, 8'hA5);
    wait_idle(0, en);
    check("a5_len", en - st, LEN_8N1);

`ifdef UART_TX_PARITY_EN
    send1(0, 8'h07, acc);
    capture(0, dat, par, st);
    check("par_even_bit", par, 1);
    wait_idle(0, en);
    check("par_even_len", en - st, 110);
    send1(1, 8'h07, acc);
    capture(1, dat, par, st);
    check("par_odd_bit", par, 0);
    wait_idle(1, en);
    check("par_odd_len", en - st, 110);
`endif

    // 7 data bits, 2 stop bits, 0x7F
    send1(1, 8'h7F, acc);
    capture(1, dat, par, st);
    check("b7_latency", st - acc, 1);
    check("b7_data", dat, 8'h7F);
    wait_idle(1, en);
    check("b7_len", en - st, LEN_7N2);

    // s_valid held for 0x01..0x08 through a 4-deep FIFO
    fork
      begin : stim
        int k = 1;
        int n = 0;
        bit r;
        s_valid[0] = 1'b1;
        while (k <= 8 && n < 2000) begin
          @(negedge clk);
          d0 = k[7:0];
          r  = rdy[0];
          if (cnt0 == 3'd4 && !rdy[0]) saw_full = 1'b1;
          @(posedge clk);
          if (r) k++;
          n++;
        end
        @(negedge clk);
        s_valid[0] = 1'b0;
      end
      begin : rx
        for (int b = 0; b < 8; b++) begin
          capture(0, dat2, par2, st2);
          check("fifo_data", dat2, b + 1);
          if (b > 0) check("fifo_gap", st2 - prev, LEN_8N1);
          prev = st2;
        end
      end
    join
    check("fifo_saw_full", int'(saw_full), 1);
    wait_idle(0, en);

    // push coinciding with a pop at count 3, then at count 4
    @(negedge clk);
    s_valid[0] = 1'b1;
    d0 = 8'h10;
    @(posedge clk);
    #1 acc = cyc;
    for (int v = 8'h11; v <= 8'h13; v++) begin
      @(negedge clk);
      d0 = v[7:0];
      @(posedge clk);
    end
    @(negedge clk);
    s_valid[0] = 1'b0;
    do @(negedge clk); while (cyc < acc + LEN_8N1);
    check("pp3_pre_count", int'(cnt0), 3);
    s_valid[0] = 1'b1;
    d0 = 8'h14;
    tick(1);
    check("pp3_count", int'(cnt0), 3);
    check("pp3_tx", int'(txl[0]), 0);
    @(negedge clk);
    d0 = 8'h15;
    tick(1);
    check("pp4_pre_count", int'(cnt0), 4);
    @(negedge clk);
    s_valid[0] = 1'b0;
    do @(negedge clk); while (cyc < acc + 2 * LEN_8N1);
    s_valid[0] = 1'b1;
    d0 = 8'h16;
    check("pp4_ready", int'(rdy[0]), 0);
    tick(1);
    check("pp4_count", int'(cnt0), 3);
    @(negedge clk);
    s_valid[0] = 1'b0;
    wait_idle(0, en);

    // reset during data bit 3 with two characters queued
    @(negedge clk);
    s_valid[0] = 1'b1;
    d0 = 8'h00;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    d0 = 8'h11;
    @(posedge clk);
    @(negedge clk);
    d0 = 8'h22;
    @(posedge clk);
    @(negedge clk);
    s_valid[0] = 1'b0;
    do tick(1); while (cyc < acc + 46);
    check("prerst_tx", int'(txl[0]), 0);
    check("prerst_count", int'(cnt0), 2);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", int'(txl[0]), 1);
    check("midrst_count", int'(cnt0), 0);
    check("midrst_busy", int'(bsy[0]), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    send1(0, 8'h3C, acc);
    capture(0, dat, par, st);
    check("post_rst_latency", st - acc, 1);
    check("post_rst_data", dat, 8'h3C);
    wait_idle(0, en);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
